// File: rtl/quad_encoder_array_if.sv
// Signal bundle between the encoder pins/controls and the quad_encoder_array front end.
// The master drives the raw A/B pins and controls; the slave returns positions, velocities and flags.
interface quad_encoder_array_if #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned COUNT_WIDTH = 24,
  parameter int unsigned VEL_WIDTH   = 16
);
  logic [CHANNELS-1:0]             quad_a;
  logic [CHANNELS-1:0]             quad_b;
  logic [CHANNELS-1:0]             zero;
  logic [CHANNELS-1:0]             error_clear;
  logic [CHANNELS*COUNT_WIDTH-1:0] count;
  logic [CHANNELS*VEL_WIDTH-1:0]   velocity;
  logic                            vel_valid;
  logic [CHANNELS-1:0]             error;

  modport master (
    output quad_a, quad_b, zero, error_clear,
    input  count, velocity, vel_valid, error
  );

  modport slave (
    input  quad_a, quad_b, zero, error_clear,
    output count, velocity, vel_valid, error
  );
endinterface

// File: rtl/quad_encoder_array.sv
// N-channel quadrature front end: sync, glitch filter, x4 decode, wrapping position,
// sticky illegal-transition flag and a shared fixed-gate velocity estimate.
module quad_encoder_array #(
  parameter int unsigned CHANNELS      = 2,
  parameter int unsigned COUNT_WIDTH   = 24,
  parameter int unsigned FILTER_CYCLES = 100,
  parameter int unsigned VEL_PERIOD    = 32000,
  parameter int unsigned VEL_WIDTH     = 16
) (
  input logic                 clk,
  input logic                 reset_n,
  quad_encoder_array_if.slave bus
);

  localparam int unsigned StabW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned GateW = $clog2(VEL_PERIOD);
  localparam logic [StabW-1:0] StabMax  = StabW'(FILTER_CYCLES);
  localparam logic [StabW-1:0] StabLast = StabW'(FILTER_CYCLES - 1);
  localparam logic [GateW-1:0] GateLast = GateW'(VEL_PERIOD - 1);
  localparam logic [VEL_WIDTH-1:0] VelMax = {1'b0, {(VEL_WIDTH - 1){1'b1}}};
  localparam logic [VEL_WIDTH-1:0] VelMin = {1'b1, {(VEL_WIDTH - 1){1'b0}}};

  logic [GateW-1:0] gate_q;
  logic             gate_end;
  logic             vel_valid_q;
  logic [CHANNELS*COUNT_WIDTH-1:0] count_all;
  logic [CHANNELS*VEL_WIDTH-1:0]   velocity_all;
  logic [CHANNELS-1:0]             error_all;

  assign gate_end = (gate_q == GateLast);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gate_q      <= '0;
      vel_valid_q <= 1'b0;
    end else begin
      gate_q      <= gate_end ? '0 : gate_q + GateW'(1);
      vel_valid_q <= gate_end;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [1:0]             meta_q, sync_q, prev_q, acc_q;
    logic [StabW-1:0]       stab_q;
    logic                   init_q, err_q;
    logic                   stable, accept, step_up, step_dn, illegal;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, snap_q, diff;
    logic [COUNT_WIDTH-VEL_WIDTH:0] diff_upper;
    logic [VEL_WIDTH-1:0]   vel_q, vel_sat;

    // A level is taken only while it is also unchanged this cycle, so a change that lands on
    // the terminal stab count cannot slip through after a single cycle of stability.
    assign stable = (sync_q == prev_q);
    assign accept = stable && (stab_q == StabLast) && (!init_q || (sync_q != acc_q));

    always_comb begin
      step_up = 1'b0;
      step_dn = 1'b0;
      illegal = 1'b0;
      if (accept && init_q) begin
        case ({acc_q, sync_q})
          4'b0001, 4'b0111, 4'b1110, 4'b1000: step_up = 1'b1;
          4'b0100, 4'b1101, 4'b1011, 4'b0010: step_dn = 1'b1;
          default:                            illegal = 1'b1;
        endcase
      end
    end

    always_comb begin
      cnt_d = cnt_q;
      if (step_up) begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end else if (step_dn) begin
        cnt_d = cnt_q - COUNT_WIDTH'(1);
      end
      if (bus.zero[i]) begin
        cnt_d = '0;
      end
    end

    // Modulo difference stays correct across a position wrap; clamp it into the velocity range.
    always_comb begin
      diff       = cnt_d - snap_q;
      diff_upper = diff[COUNT_WIDTH-1:VEL_WIDTH-1];
      if ((diff_upper == '0) || (diff_upper == '1)) begin
        vel_sat = diff[VEL_WIDTH-1:0];
      end else if (diff[COUNT_WIDTH-1]) begin
        vel_sat = VelMin;
      end else begin
        vel_sat = VelMax;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        meta_q <= 2'b00;
        sync_q <= 2'b00;
        prev_q <= 2'b00;
        acc_q  <= 2'b00;
        stab_q <= '0;
        init_q <= 1'b0;
        err_q  <= 1'b0;
        cnt_q  <= '0;
        snap_q <= '0;
        vel_q  <= '0;
      end else begin
        meta_q <= {bus.quad_a[i], bus.quad_b[i]};
        sync_q <= meta_q;
        prev_q <= sync_q;
        if (!stable) begin
          stab_q <= '0;
        end else if (stab_q != StabMax) begin
          stab_q <= stab_q + StabW'(1);
        end
        if (accept) begin
          acc_q  <= sync_q;
          init_q <= 1'b1;
        end
        if (illegal) begin
          err_q <= 1'b1;
        end else if (bus.error_clear[i]) begin
          err_q <= 1'b0;
        end
        cnt_q <= cnt_d;
        if (gate_end) begin
          snap_q <= cnt_d;
          vel_q  <= vel_sat;
        end else if (bus.zero[i]) begin
          snap_q <= '0;
        end
      end
    end

    assign count_all[i*COUNT_WIDTH +: COUNT_WIDTH] = cnt_q;
    assign velocity_all[i*VEL_WIDTH +: VEL_WIDTH]  = vel_q;
    assign error_all[i]                            = err_q;
  end

  assign bus.count     = count_all;
  assign bus.velocity  = velocity_all;
  assign bus.error     = error_all;
  assign bus.vel_valid = vel_valid_q;

endmodule
